// File: rtl/inst_rom_fetch.sv
// Instruction ROM fetch unit. A read-only table is looked up combinationally
// and the result is written into a 2-entry in-order response buffer.
module inst_rom_fetch #(
  parameter int                 ADDR_W = 7,
  parameter int                 DATA_W = 8,
  parameter int                 DEPTH  = 128,
  parameter logic [DATA_W-1:0]  FILL   = '1,
  parameter int                 CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic [CNT_W-1:0]  fetch_cnt_o
);

  localparam int ROM_N = 1 << ADDR_W;

  // The table spans the whole address space so the lookup needs no range
  // guard; unpopulated slots carry FILL and the error flag.
  logic [DATA_W-1:0] rom_data [ROM_N];
  logic [ROM_N-1:0]  rom_err;

  for (genvar gi = 0; gi < ROM_N; gi++) begin : g_rom
    if (gi < DEPTH) begin : g_pop
      assign rom_data[gi] = DATA_W'(gi);
      assign rom_err[gi]  = 1'b0;
    end else begin : g_fill
      assign rom_data[gi] = FILL;
      assign rom_err[gi]  = 1'b1;
    end
  end

  logic [DATA_W-1:0] fetch_data;
  logic              fetch_err;

  assign fetch_data = rom_data[req_addr_i];
  assign fetch_err  = rom_err[req_addr_i];

  // Response buffer state
  logic [DATA_W-1:0] buf_data_q [2];
  logic [1:0]        buf_err_q;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              push, pop;

  always_comb begin
    req_ready_o = (occ_q != 2'd2) && !flush_i;
    push        = req_valid_i && req_ready_o;
    pop         = (occ_q != 2'd0) && rsp_ready_i;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    cnt_d       = cnt_q;

    if (flush_i) begin
      occ_d    = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      if (push && !pop)      occ_d = occ_q + 2'd1;
      else if (pop && !push) occ_d = occ_q - 2'd1;
    end

    // Saturating count of accepted requests; flush leaves it alone.
    if (push && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Payload storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (push) begin
      buf_data_q[wr_ptr_q] <= fetch_data;
      buf_err_q[wr_ptr_q]  <= fetch_err;
    end
  end

  always_comb begin
    rsp_valid_o = (occ_q != 2'd0);
    rsp_data_o  = rsp_valid_o ? buf_data_q[rd_ptr_q] : '0;
    rsp_err_o   = rsp_valid_o ? buf_err_q[rd_ptr_q]  : 1'b0;
  end

  assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_inst_rom_fetch.sv
// Scoreboard bench for inst_rom_fetch: a queue model of the response buffer
// and a saturating counter model predict every output cycle by cycle.
module tb_inst_rom_fetch;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 100;
  localparam int CNT_W  = 3;
  localparam int CNT_MAX = 7;

  logic              clk_i = 1'b0;
  logic              rst_ni = 1'b0;
  logic              flush_i = 1'b0;
  logic              req_valid_i = 1'b0;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_err_o;
  logic [CNT_W-1:0]  fetch_cnt_o;

  inst_rom_fetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FILL(8'hFF), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .fetch_cnt_o(fetch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [DATA_W:0] exp_q [$];   // {err, data}
  int model_cnt;
  int n_cmp;
  int n_bad;

  function automatic logic [DATA_W:0] rom_model(input logic [ADDR_W-1:0] a);
    if (int'(a) >= DEPTH) return {1'b1, 8'hFF};
    return {1'b0, 1'b0, a};
  endfunction

  // {valid, err, data} expected at the buffer head right now
  function automatic logic [DATA_W+1:0] exp_rsp();
    if (exp_q.size() == 0) return '0;
    return {1'b1, exp_q[0]};
  endfunction

  function automatic logic [DATA_W+1:0] obs_rsp();
    return {rsp_valid_o, rsp_err_o, rsp_data_o};
  endfunction

  task automatic drive(input logic v, input int a, input logic rr, input logic fl, input logic rn);
    req_valid_i = v;
    req_addr_i  = ADDR_W'(a);
    rsp_ready_i = rr;
    flush_i     = fl;
    rst_ni      = rn;
    #1;
  endtask

  // Advance the model by one edge using the currently driven inputs, then the DUT.
  task automatic tick();
    bit acc, pp;
    acc = rst_ni && !flush_i && req_valid_i && (exp_q.size() < 2);
    pp  = rst_ni && !flush_i && rsp_ready_i && (exp_q.size() > 0);
    if (!rst_ni) begin
      exp_q.delete();
      model_cnt = 0;
    end else if (flush_i) begin
      exp_q.delete();
    end else begin
      if (pp) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(rom_model(req_addr_i));
        if (model_cnt < CNT_MAX) model_cnt++;
      end
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    tick();
    tick();
    n_cmp++;
    if (obs_rsp() !== '0) begin
      n_bad++; $display("FAIL reset_rsp: got %h want %h", obs_rsp(), 10'h0);
    end
    n_cmp++;
    if (fetch_cnt_o !== '0) begin
      n_bad++; $display("FAIL reset_cnt: got %0d want 0", fetch_cnt_o);
    end
    drive(0, 0, 1, 0, 1);
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
    end
    tick();
    $display("txn reset: done");
  endtask

  task automatic test_single_fetch();
    drive(1, 43, 1, 0, 1);
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL single_ready: got %b want 1", req_ready_o);
    end
    tick();
    drive(0, 0, 1, 0, 1);
    n_cmp++;
    if (obs_rsp() !== exp_rsp() || exp_rsp() !== {1'b1, 1'b0, 8'd43}) begin
      n_bad++; $display("FAIL single_rsp: got %h want %h", obs_rsp(), exp_rsp());
    end
    n_cmp++;
    if (fetch_cnt_o !== CNT_W'(model_cnt)) begin
      n_bad++; $display("FAIL single_cnt: got %0d want %0d", fetch_cnt_o, model_cnt);
    end
    tick();
    n_cmp++;
    if (obs_rsp() !== exp_rsp()) begin
      n_bad++; $display("FAIL single_drain: got %h want %h", obs_rsp(), exp_rsp());
    end
    $display("txn single_fetch: addr 43 data %0d", rsp_data_o);
  endtask

  task automatic test_back_pressure();
    drive(1, 5, 0, 0, 1); tick();
    drive(1, 6, 0, 0, 1); tick();
    drive(1, 7, 0, 0, 1);
    n_cmp++;
    if (req_ready_o !== 1'b0) begin
      n_bad++; $display("FAIL bp_ready_full: got %b want 0", req_ready_o);
    end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs_rsp() !== exp_rsp()) begin
        n_bad++; $display("FAIL bp_head_hold: got %h want %h", obs_rsp(), exp_rsp());
      end
      tick();
    end
    drive(0, 0, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_rsp() !== exp_rsp()) begin
        n_bad++; $display("FAIL bp_drain%0d: got %h want %h", i, obs_rsp(), exp_rsp());
      end
      $display("txn back_pressure: drain %0d data %0d", i, rsp_data_o);
      tick();
    end
    n_cmp++;
    if (fetch_cnt_o !== CNT_W'(model_cnt)) begin
      n_bad++; $display("FAIL bp_cnt: got %0d want %0d", fetch_cnt_o, model_cnt);
    end
  endtask

  task automatic test_out_of_range();
    int addrs [3] = '{120, 99, 100};
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, addrs[i], 1, 0, 1);
      else       drive(0, 0, 1, 0, 1);
      n_cmp++;
      if (obs_rsp() !== exp_rsp()) begin
        n_bad++; $display("FAIL oor_rsp%0d: got %h want %h", i, obs_rsp(), exp_rsp());
      end
      if (i > 0) $display("txn out_of_range: addr %0d data %h err %b", addrs[i-1], rsp_data_o, rsp_err_o);
      tick();
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drive(1, i, 1, 0, 1);
      else        drive(0, 0, 1, 0, 1);
      n_cmp++;
      if (req_ready_o !== 1'b1) begin
        n_bad++; $display("FAIL stream_ready%0d: got %b want 1", i, req_ready_o);
      end
      n_cmp++;
      if (obs_rsp() !== exp_rsp()) begin
        n_bad++; $display("FAIL stream_rsp%0d: got %h want %h", i, obs_rsp(), exp_rsp());
      end
      n_cmp++;
      if (fetch_cnt_o !== CNT_W'(model_cnt)) begin
        n_bad++; $display("FAIL stream_cnt%0d: got %0d want %0d", i, fetch_cnt_o, model_cnt);
      end
      $display("txn streaming: cycle %0d valid %b data %0d", i, rsp_valid_o, rsp_data_o);
      tick();
    end
  endtask

  task automatic test_flush();
    drive(1, 10, 0, 0, 1); tick();
    drive(1, 11, 0, 0, 1); tick();
    drive(1, 12, 0, 1, 1);
    n_cmp++;
    if (req_ready_o !== 1'b0) begin
      n_bad++; $display("FAIL flush_ready: got %b want 0", req_ready_o);
    end
    n_cmp++;
    if (obs_rsp() !== exp_rsp()) begin
      n_bad++; $display("FAIL flush_pre: got %h want %h", obs_rsp(), exp_rsp());
    end
    tick();
    drive(0, 0, 1, 0, 1);
    n_cmp++;
    if (obs_rsp() !== exp_rsp()) begin
      n_bad++; $display("FAIL flush_post: got %h want %h", obs_rsp(), exp_rsp());
    end
    n_cmp++;
    if (fetch_cnt_o !== CNT_W'(model_cnt)) begin
      n_bad++; $display("FAIL flush_cnt: got %0d want %0d", fetch_cnt_o, model_cnt);
    end
    $display("txn flush: valid %b cnt %0d", rsp_valid_o, fetch_cnt_o);
    tick();
  endtask

  task automatic test_reset_midstream();
    drive(1, 20, 0, 0, 1); tick();
    drive(1, 21, 0, 0, 1); tick();
    drive(1, 22, 1, 0, 0);
    tick();
    n_cmp++;
    if ({obs_rsp(), fetch_cnt_o} !== '0) begin
      n_bad++; $display("FAIL rstmid_outputs: got %h/%0d want 0/0", obs_rsp(), fetch_cnt_o);
    end
    drive(0, 0, 1, 0, 1);
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_ready: got %b want 1", req_ready_o);
    end
    $display("txn reset_midstream: outputs cleared");
    for (int i = 0; i <= 9; i++) begin
      if (i < 9) drive(1, 30 + i, 1, 0, 1);
      else       drive(0, 0, 1, 0, 1);
      n_cmp++;
      if (obs_rsp() !== exp_rsp()) begin
        n_bad++; $display("FAIL sat_rsp%0d: got %h want %h", i, obs_rsp(), exp_rsp());
      end
      tick();
    end
    n_cmp++;
    if (fetch_cnt_o !== 3'd7 || model_cnt != CNT_MAX) begin
      n_bad++; $display("FAIL sat_cnt: got %0d want 7", fetch_cnt_o);
    end
    $display("txn saturation: cnt %0d", fetch_cnt_o);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    model_cnt = 0;
    @(negedge clk_i);
    test_reset();
    test_single_fetch();
    test_back_pressure();
    test_out_of_range();
    test_streaming();
    test_flush();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
